// File: rtl/data_io_pkg.sv
// Shared sizing and config-field layout helpers for the data_io block.
// Field order from LSB: SEL_IN, SEL_OUT, IN_REG, OUT_REG.
package data_io_pkg;

    localparam int W_DEF          = 6;
    localparam int WW_DEF         = 3;
    localparam int EXTDATAIN_DEF  = 2;
    localparam int EXTDATAOUT_DEF = 3;

    function automatic int sel_out_base(int w, int extdatain);
        return $clog2(extdatain) * w;
    endfunction

    function automatic int in_reg_base(int w, int ww, int extdatain, int extdataout);
        return sel_out_base(w, extdatain) + $clog2(w / ww) * ww * extdataout;
    endfunction

    function automatic int out_reg_base(int w, int ww, int extdatain, int extdataout);
        return in_reg_base(w, ww, extdatain, extdataout) + w;
    endfunction

    function automatic int cfg_bits(int w, int ww, int extdatain, int extdataout);
        return out_reg_base(w, ww, extdatain, extdataout) + ww * extdataout;
    endfunction

    localparam int SEL_IN_BASE  = 0;
    localparam int SEL_OUT_BASE = SEL_IN_BASE + sel_out_base(W_DEF, EXTDATAIN_DEF);
    localparam int IN_REG_BASE  = SEL_OUT_BASE + $clog2(W_DEF / WW_DEF) * WW_DEF * EXTDATAOUT_DEF;
    localparam int OUT_REG_BASE = IN_REG_BASE + W_DEF;
    localparam int CFG_BITS_DEF = OUT_REG_BASE + WW_DEF * EXTDATAOUT_DEF;

endpackage

// File: rtl/data_io_block_seq_cfg_chain.sv
// Serial config chain with burst counter and registered "loaded" flag.
// DATA_IO_PARALLEL_CFG_EN adds a one-cycle parallel load that beats shifting.
module data_io_cfg_chain
    import data_io_pkg::*;
#(
    parameter int CFG_BITS = CFG_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en_i,
    input  logic                cfg_in_i,
`ifdef DATA_IO_PARALLEL_CFG_EN
    input  logic [CFG_BITS-1:0] cfg_par_i,
    input  logic                cfg_par_load_i,
`endif
    output logic [CFG_BITS-1:0] cfg_o,
    output logic                cfg_out_o,
    output logic                loaded_o
);

    localparam int CW = $clog2(CFG_BITS + 1);

    logic [CFG_BITS-1:0] cfg_q, cfg_d;
    logic [CW-1:0]       count_q, count_d;
    logic                prev_shift_q, prev_shift_d;
    logic                loaded_q, loaded_d;

    always_comb begin
        cfg_d        = cfg_q;
        count_d      = count_q;
        prev_shift_d = shift_en_i;
        loaded_d     = (count_q == CW'(CFG_BITS)) && !shift_en_i;
`ifdef DATA_IO_PARALLEL_CFG_EN
        if (cfg_par_load_i) begin
            cfg_d        = cfg_par_i;
            count_d      = CW'(CFG_BITS);
            prev_shift_d = 1'b0;
        end else
`endif
        if (shift_en_i) begin
            cfg_d = {cfg_q[CFG_BITS-2:0], cfg_in_i};
            // A new burst restarts the count; a continuing one saturates.
            if (!prev_shift_q)
                count_d = CW'(1);
            else if (count_q != CW'(CFG_BITS))
                count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q        <= '0;
            count_q      <= '0;
            prev_shift_q <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            cfg_q        <= cfg_d;
            count_q      <= count_d;
            prev_shift_q <= prev_shift_d;
            loaded_q     <= loaded_d;
        end
    end

    assign cfg_o     = cfg_q;
    assign cfg_out_o = cfg_q[CFG_BITS-1];
    assign loaded_o  = loaded_q;

endmodule

// File: rtl/muxn.sv
// N-input one-bit select mux; a select value outside 0..N-1 yields 0.
module muxn #(
    parameter int N  = 2,
    parameter int SW = 1
) (
    input  logic [N-1:0]  d_i,
    input  logic [SW-1:0] sel_i,
    output logic          y_o
);

    always_comb begin
        y_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel_i == SW'(i)) y_o = d_i[i];
        end
    end

endmodule

// File: rtl/data_io_block_seq.sv
// Fabric-edge I/O block: configurable per-bit routing with optional output registers,
// all gated off until the config chain is loaded. Optional macro: DATA_IO_PARALLEL_CFG_EN.
module data_io_block_seq
    import data_io_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int WW          = WW_DEF,
    parameter int EXTDATAIN   = EXTDATAIN_DEF,
    parameter int EXTDATAOUT  = EXTDATAOUT_DEF,
    parameter int WN          = W / WW,
    parameter int SEL_PER_IN  = $clog2(EXTDATAIN),
    parameter int SEL_PER_OUT = $clog2(WN),
    parameter int CFG_BITS    = cfg_bits(W, WW, EXTDATAIN, EXTDATAOUT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               data_in,
    output logic [W-1:0]               data_out,
    input  logic [WW*EXTDATAIN-1:0]    external_input,
    output logic [WW*EXTDATAOUT-1:0]   external_output,
    input  logic                       cfg_shift_en,
    input  logic                       cfg_in,
`ifdef DATA_IO_PARALLEL_CFG_EN
    input  logic [CFG_BITS-1:0]        cfg_par,
    input  logic                       cfg_par_load,
`endif
    output logic                       cfg_out,
    output logic                       cfg_loaded
);

    localparam int NOUT = WW * EXTDATAOUT;
    localparam int SOB  = SEL_IN_BASE + sel_out_base(W, EXTDATAIN);
    localparam int IRB  = SEL_IN_BASE + in_reg_base(W, WW, EXTDATAIN, EXTDATAOUT);
    localparam int ORB  = SEL_IN_BASE + out_reg_base(W, WW, EXTDATAIN, EXTDATAOUT);

    logic [CFG_BITS-1:0] cfg;
    logic [W-1:0]        in_mux, in_pipe_q, in_pipe_d, in_reg;
    logic [NOUT-1:0]     out_mux, out_pipe_q, out_pipe_d, out_reg;

    data_io_cfg_chain #(.CFG_BITS(CFG_BITS)) u_cfg (
        .clk            (clk),
        .rst            (rst),
        .shift_en_i     (cfg_shift_en),
        .cfg_in_i       (cfg_in),
`ifdef DATA_IO_PARALLEL_CFG_EN
        .cfg_par_i      (cfg_par),
        .cfg_par_load_i (cfg_par_load),
`endif
        .cfg_o          (cfg),
        .cfg_out_o      (cfg_out),
        .loaded_o       (cfg_loaded)
    );

    // Bit j of every lane picks bit j of the selected external port.
    for (genvar b = 0; b < W; b++) begin : g_in
        logic [EXTDATAIN-1:0] cand;
        for (genvar p = 0; p < EXTDATAIN; p++) begin : g_cand
            assign cand[p] = external_input[WW*p + (b % WW)];
        end
        muxn #(.N(EXTDATAIN), .SW(SEL_PER_IN)) u_mux (
            .d_i   (cand),
            .sel_i (cfg[SEL_IN_BASE + SEL_PER_IN*b +: SEL_PER_IN]),
            .y_o   (in_mux[b])
        );
    end

    for (genvar b = 0; b < NOUT; b++) begin : g_out
        logic [WN-1:0] cand;
        for (genvar l = 0; l < WN; l++) begin : g_cand
            assign cand[l] = data_in[WW*l + (b % WW)];
        end
        muxn #(.N(WN), .SW(SEL_PER_OUT)) u_mux (
            .d_i   (cand),
            .sel_i (cfg[SOB + SEL_PER_OUT*b +: SEL_PER_OUT]),
            .y_o   (out_mux[b])
        );
    end

    assign in_reg     = cfg[IRB +: W];
    assign out_reg    = cfg[ORB +: NOUT];
    assign in_pipe_d  = cfg_loaded ? in_mux  : '0;
    assign out_pipe_d = cfg_loaded ? out_mux : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_pipe_q  <= '0;
            out_pipe_q <= '0;
        end else begin
            in_pipe_q  <= in_pipe_d;
            out_pipe_q <= out_pipe_d;
        end
    end

    assign data_out        = cfg_loaded ? ((in_mux & ~in_reg) | (in_pipe_q & in_reg)) : '0;
    assign external_output = cfg_loaded ? ((out_mux & ~out_reg) | (out_pipe_q & out_reg)) : '0;

endmodule

// File: tb/tb_data_io_block_seq.sv
// Self-checking bench for data_io_block_seq; the parallel-load case is built only
// when DATA_IO_PARALLEL_CFG_EN is defined.
module tb_data_io_block_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  data_in, data_out, external_input;
    logic [8:0]  external_output;
    logic        cfg_shift_en, cfg_in, cfg_out, cfg_loaded;
`ifdef DATA_IO_PARALLEL_CFG_EN
    logic [29:0] cfg_par;
    logic        cfg_par_load;
`endif

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    data_io_block_seq dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .data_out        (data_out),
        .external_input  (external_input),
        .external_output (external_output),
        .cfg_shift_en    (cfg_shift_en),
        .cfg_in          (cfg_in),
`ifdef DATA_IO_PARALLEL_CFG_EN
        .cfg_par         (cfg_par),
        .cfg_par_load    (cfg_par_load),
`endif
        .cfg_out         (cfg_out),
        .cfg_loaded      (cfg_loaded)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input logic [15:0] v);
        exp_q.push_back({16'h0, v});
    endtask

    // Observed word is {cfg_loaded, external_output, data_out}.
    task automatic sb_check(input string tag);
        logic [31:0] e;
        logic [31:0] got;
        got = {16'h0, cfg_loaded, external_output, data_out};
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = ~got;
        check(tag, got, e);
    endtask

    function automatic logic [29:0] mk_cfg(input logic [5:0] sel_in, input logic [8:0] sel_out,
                                           input logic [5:0] in_reg, input logic [8:0] out_reg);
        return {out_reg, in_reg, sel_out, sel_in};
    endfunction

    function automatic logic [5:0] route_in(input logic [5:0] ext, input logic [5:0] sel);
        logic [5:0] r;
        for (int b = 0; b < 6; b++) r[b] = ext[3*int'(sel[b]) + (b % 3)];
        return r;
    endfunction

    function automatic logic [8:0] route_out(input logic [5:0] din, input logic [8:0] sel);
        logic [8:0] r;
        for (int b = 0; b < 9; b++) r[b] = din[3*int'(sel[b]) + (b % 3)];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_cfg(input logic [29:0] v, input int nbits);
        for (int i = 29; i > 29 - nbits; i--) begin
            cfg_shift_en = 1'b1;
            cfg_in       = v[i];
            step();
        end
        cfg_shift_en = 1'b0;
        cfg_in       = 1'b0;
    endtask

    initial begin : stim
        logic [29:0] cfg_v;
        logic [31:0] r0, r1, r2, r3;
        logic [5:0]  ri, prev_i;
        logic [8:0]  ro, prev_o;

        rst = 1'b1; cfg_shift_en = 1'b0; cfg_in = 1'b0;
        data_in = '0; external_input = '0;
`ifdef DATA_IO_PARALLEL_CFG_EN
        cfg_par = '0; cfg_par_load = 1'b0;
`endif
        step(); step();
        @(negedge clk);
        check("rst_cfg_out", {31'h0, cfg_out}, 32'h0);
        push(16'h0);
        sb_check("rst_outputs");
        step();
        rst = 1'b0;

        // Unconfigured: everything gated to zero.
        external_input = 6'b101_011;
        for (int i = 0; i < 10; i++) begin
            push(16'h0);
            @(negedge clk);
            sb_check("unconfigured");
            step();
        end

        // All selects 0, all combinational.
        external_input = 6'b110_001;
        data_in        = 6'b111_010;
        shift_cfg(mk_cfg(6'h00, 9'h000, 6'h00, 9'h000), 30);
        @(negedge clk);
        check("loaded_early", {31'h0, cfg_loaded}, 32'h0);
        step();
        push({1'b1, 9'b010_010_010, 6'b001_001});
        @(negedge clk);
        sb_check("comb_sel0");

        // SEL_IN=1 everywhere, inputs registered.
        external_input = 6'b000_111;
        shift_cfg(mk_cfg(6'h3F, 9'h000, 6'h3F, 9'h000), 30);
        step();
        push({1'b1, 9'b010_010_010, 6'b000_000});
        @(negedge clk);
        sb_check("reg_first");
        step();
        external_input = 6'b111_000;
        push({1'b1, 9'b010_010_010, 6'b000_000});
        @(negedge clk);
        sb_check("reg_hold");
        step();
        push({1'b1, 9'b010_010_010, 6'b111_111});
        @(negedge clk);
        sb_check("reg_update");

        // Partial burst must not raise cfg_loaded.
        shift_cfg(30'h2AAA_AAAA, 20);
        for (int i = 0; i < 5; i++) begin
            push(16'h0);
            @(negedge clk);
            sb_check("partial");
            step();
        end

        // Full burst of a random mixed configuration, then random traffic.
        r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
        cfg_v = mk_cfg(r0[5:0], r1[8:0], r2[5:0], r3[8:0]);
        shift_cfg(cfg_v, 30);
        push(16'h0);
        @(negedge clk);
        sb_check("rand_pre_loaded");
        step();
        prev_i = '0;
        prev_o = '0;
        for (int i = 0; i < 20; i++) begin
            r0 = $urandom(); r1 = $urandom();
            external_input = r0[5:0];
            data_in        = r1[5:0];
            ri = route_in(external_input, cfg_v[5:0]);
            ro = route_out(data_in, cfg_v[14:6]);
            push({1'b1, (ro & ~cfg_v[29:21]) | (prev_o & cfg_v[29:21]),
                        (ri & ~cfg_v[20:15]) | (prev_i & cfg_v[20:15])});
            @(negedge clk);
            sb_check("rand_traffic");
            prev_i = ri;
            prev_o = ro;
            step();
        end

        // Reset landing on shift bit 16 discards the partial load.
        shift_cfg(30'h3FFF_FFFF, 15);
        cfg_shift_en = 1'b1;
        cfg_in       = 1'b1;
        rst          = 1'b1;
        step();
        rst          = 1'b0;
        cfg_shift_en = 1'b0;
        cfg_in       = 1'b0;
        @(negedge clk);
        check("midshift_rst_cfg_out", {31'h0, cfg_out}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            push(16'h0);
            @(negedge clk);
            sb_check("midshift_rst_idle");
            step();
        end

        external_input = 6'b011_101;
        data_in        = 6'b100_110;
        shift_cfg(mk_cfg(6'b000_111, 9'b000_000_111, 6'h00, 9'b100_000_000), 30);
        @(negedge clk);
        check("reload_cfg_out", {31'h0, cfg_out}, 32'h1);
        check("reload_loaded_early", {31'h0, cfg_loaded}, 32'h0);
        step();
        push({1'b1, 9'b010_110_100, 6'b101_011});
        @(negedge clk);
        sb_check("reload_first");
        step();
        push({1'b1, 9'b110_110_100, 6'b101_011});
        @(negedge clk);
        sb_check("reload_reg_bit");

`ifdef DATA_IO_PARALLEL_CFG_EN
        step();
        cfg_par      = mk_cfg(6'h00, 9'h1FF, 6'h00, 9'h000);
        cfg_par_load = 1'b1;
        cfg_shift_en = 1'b1;
        cfg_in       = 1'b1;
        step();
        cfg_par_load = 1'b0;
        cfg_shift_en = 1'b0;
        cfg_in       = 1'b0;
        @(negedge clk);
        check("par_cfg_out", {31'h0, cfg_out}, 32'h0);
        step();
        push({1'b1, 9'b100_100_100, 6'b101_101});
        @(negedge clk);
        sb_check("par_load");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_io_block_seq.md
Name: data_io_block_seq

Overview:
- Next-generation fabric I/O block. Routes WW-bit external input ports onto the W-bit fabric data bus, and fabric data lanes onto WW-bit external output ports, through per-bit select muxes.
- Adds what the combinational version lacks: an internal serially loaded configuration chain with a load counter, a per-bit registered/combinational mode, and output gating until configuration completes.
- Sits at the fabric edge; its cfg chain is daisy-chained with neighbouring tiles.

Parameters:
- W, 6: fabric data width; must be a multiple of WW.
- WW, 3: external port width.
- EXTDATAIN, 2: number of external input ports; must be >= 2.
- EXTDATAOUT, 3: number of external output ports.
- WN, W/WW: lanes per fabric bus; must be >= 2.
- SEL_PER_IN, $clog2(EXTDATAIN): select bits per data_out bit.
- SEL_PER_OUT, $clog2(WN): select bits per external_output bit.
- CFG_BITS, SEL_PER_IN*W + SEL_PER_OUT*WW*EXTDATAOUT + W + WW*EXTDATAOUT: config chain length (30 at defaults).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- data_in  input  W  fabric data toward external outputs.
- data_out  output  W  fabric data from external inputs.
- external_input  input  WW*EXTDATAIN  packed external input ports; port i occupies bits [WW*i +: WW].
- external_output  output  WW*EXTDATAOUT  packed external output ports.
- cfg_shift_en  input  1  shift the config chain this cycle.
- cfg_in  input  1  serial config data in.
- cfg_out  output  1  serial config data out; equals cfg[CFG_BITS-1].
- cfg_loaded  output  1  high when configuration is complete and outputs are live.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high on rst.
- Reset clears:
  - the cfg register to all 0;
  - the bit counter to 0;
  - the previous-cycle shift_en register;
  - all data_out and external_output pipeline flops.
- Reset values: cfg_loaded=0, cfg_out=0, data_out=0, external_output=0. rst overrides a shift in the same cycle.
- Config register layout, LSB upward:
  - SEL_IN field: SEL_PER_IN*W bits. Field for data_out bit b is at [SEL_PER_IN*b +: SEL_PER_IN].
  - SEL_OUT field: SEL_PER_OUT*WW*EXTDATAOUT bits. Field for external_output bit b is at [SEL_PER_OUT*b +: SEL_PER_OUT].
  - IN_REG: W bits.
  - OUT_REG: WW*EXTDATAOUT bits.
- Shift: when cfg_shift_en=1, cfg <= {cfg[CFG_BITS-2:0], cfg_in}. The first bit shifted in ends at the MSB after CFG_BITS shifts.
- Counter, width $clog2(CFG_BITS+1):
  - On a shift cycle where the previous shift_en=0, the counter loads 1.
  - Otherwise on a shift cycle it increments, saturating at CFG_BITS.
  - It holds when no shift occurs.
- cfg_loaded = (count==CFG_BITS) && !cfg_shift_en, registered. It is low during any shift and rises one cycle after the shift ends.
- A partial reload (fewer than CFG_BITS shifts) leaves cfg_loaded=0 until a full burst completes.
- Input routing:
  - data_out bit j+k*WW = external_input[WW*s+j], where s is its SEL_IN field.
  - An out-of-range s (s >= EXTDATAIN) yields 0.
- Output routing:
  - external_output bit j+i*WW = data_in[WW*s+j], where s is its SEL_OUT field.
  - An out-of-range s yields 0.
- Mode bits:
  - IN_REG[b]=1: data_out[b] is taken from a flop that captures the mux result every cycle (1-cycle latency).
  - IN_REG[b]=0: data_out[b] is combinational (0 latency).
  - OUT_REG applies the same rule to external_output.
- Gating: while cfg_loaded=0, every data_out and external_output bit is forced to 0, and the pipeline flops load 0.
  - First valid registered output appears 1 cycle after cfg_loaded rises.
  - First valid combinational output appears in the same cycle cfg_loaded rises.
- Reset mid-shift: the partial configuration is discarded, and cfg_loaded stays 0 until a fresh full burst.

Optional Feature:
- Macro: DATA_IO_PARALLEL_CFG_EN.
- Defined: adds ports cfg_par (input, CFG_BITS) and cfg_par_load (input, 1).
  - When cfg_par_load=1, cfg <= cfg_par and count <= CFG_BITS in one cycle; cfg_loaded rises the next cycle.
  - If cfg_par_load and cfg_shift_en are both 1, cfg_par_load wins.
- Undefined: ports absent; serial load only.

Decomposition:
- Shared package data_io_pkg holds:
  - function cfg_bits(W,WW,EXTDATAIN,EXTDATAOUT);
  - field-offset constants SEL_IN_BASE, SEL_OUT_BASE, IN_REG_BASE, OUT_REG_BASE;
  - field-offset helper functions.
- One sub-module, data_io_cfg_chain: the shift register, counter, cfg_loaded logic and optional parallel load. It exports the cfg vector.
- Routing reuses the existing muxn.

Test Plan:
- Reset, then no config -> data_out=0, external_output=0 and cfg_loaded=0 for 10 cycles, with external_input=6'b101_011.
- Serial load of 30 bits, all SEL=0 and all modes combinational, with external_input=6'b110_001 -> after the cycle in which cfg_loaded rises: data_out=6'b001_001; with data_in=6'b111_010, external_output=9'b010_010_010.
- Load with SEL_IN=1 for all bits, IN_REG all 1, and the input stepped 6'b000_111 -> 6'b111_000 -> data_out changes exactly 1 cycle after external_input, to 6'b111_111.
- Shift 20 bits, deassert shift_en, wait 5 cycles -> cfg_loaded stays 0. Then a full 30-bit burst -> cfg_loaded=1 one cycle after the last shift.
- Assert rst during shift bit 15 -> cfg_out=0 and count=0. A subsequent full burst loads correctly.
- With DATA_IO_PARALLEL_CFG_EN: pulse cfg_par_load together with cfg_shift_en -> cfg equals cfg_par and cfg_loaded=1 on the next cycle.
